// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the SRAM port arbiter and its users.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W       = 18;
  localparam int SRAM_DATA_W       = 16;
  localparam int SRAM_READ_LATENCY = 3;

  localparam int REQ_UART = 0;
  localparam int REQ_M1   = 1;
  localparam int REQ_M2   = 2;
  localparam int REQ_M3   = 3;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-controller-side bus of the SRAM port arbiter.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W
) ();

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        lock_i;
  logic [NUM_REQ-1:0]        we_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ*DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        rd_valid_o;
  logic [DATA_W-1:0]         rd_data_o;
  logic [ADDR_W-1:0]         SRAM_address_o;
  logic [DATA_W-1:0]         SRAM_write_data_o;
  logic                      SRAM_we_n_o;
  logic [DATA_W-1:0]         SRAM_read_data_i;
  logic                      reads_pending_o;

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i, SRAM_read_data_i,
    output gnt_o, rd_valid_o, rd_data_o, SRAM_address_o, SRAM_write_data_o,
           SRAM_we_n_o, reads_pending_o
  );

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i, SRAM_read_data_i,
    input  gnt_o, rd_valid_o, rd_data_o, SRAM_address_o, SRAM_write_data_o,
           SRAM_we_n_o, reads_pending_o
  );

endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping,
// so the index i_last itself is considered only after every other one.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  // Scan in reverse priority order so the highest-priority hit is written last.
  always_comb begin
    int v_start;
    int v_idx;
    o_found = 1'b0;
    o_idx   = {IDW{1'b0}};
    v_start = (int'(i_last) + 1) % N;
    v_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      v_idx   = (v_start + k) % N;
      o_idx   = i_req[v_idx[IDW-1:0]] ? v_idx[IDW-1:0] : o_idx;
      o_found = o_found | i_req[v_idx[IDW-1:0]];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin owner of the single SRAM controller port, with burst locking
// and tagged read-data return after a fixed controller latency.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int READ_LATENCY = SRAM_READ_LATENCY
) (
  input logic          clk,
  input logic          rst,
  sram_arbiter_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                    r_owner_valid;
  logic [IDW-1:0]          r_owner_id;
  logic [IDW-1:0]          r_last_id;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [READ_LATENCY-1:0] r_tag_valid;
  logic [IDW-1:0]          r_tag_id [READ_LATENCY];

  logic                    w_access;
  logic                    w_keep;
  logic                    w_found;
  logic [IDW-1:0]          w_pick_id;
  logic [IDW-1:0]          w_sel_id;
  logic [NUM_REQ-1:0]      w_rd_valid;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDW-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = {NUM_REQ{1'b0}};
    v[id] = 1'b1;
    return v;
  endfunction

  // With no owner the port idles on requester 0's slice as a harmless read.
  assign w_sel_id = r_owner_valid ? r_owner_id : {IDW{1'b0}};
  assign w_access = r_owner_valid & bus.req_i[r_owner_id];
  assign w_keep   = w_access & bus.lock_i[r_owner_id];

  assign bus.SRAM_address_o    = bus.addr_i[w_sel_id*ADDR_W +: ADDR_W];
  assign bus.SRAM_write_data_o = bus.wdata_i[w_sel_id*DATA_W +: DATA_W];
  assign bus.SRAM_we_n_o       = ~(w_access & bus.we_i[r_owner_id]);

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .i_req   (bus.req_i),
    .i_last  (r_last_id),
    .o_found (w_found),
    .o_idx   (w_pick_id)
  );

  // Ownership, grant and read-tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_valid <= 1'b0;
      r_owner_id    <= {IDW{1'b0}};
      r_last_id     <= IDW'(NUM_REQ - 1);
      r_gnt         <= {NUM_REQ{1'b0}};
      r_tag_valid   <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tag_id[i] <= {IDW{1'b0}};
      end
    end else begin
      if (w_keep) begin
        r_owner_valid <= r_owner_valid;
        r_owner_id    <= r_owner_id;
        r_last_id     <= r_last_id;
        r_gnt         <= r_gnt;
      end else if (w_found) begin
        r_owner_valid <= 1'b1;
        r_owner_id    <= w_pick_id;
        r_last_id     <= w_pick_id;
        r_gnt         <= f_onehot(w_pick_id);
      end else begin
        r_owner_valid <= 1'b0;
        r_owner_id    <= r_owner_id;
        r_last_id     <= r_last_id;
        r_gnt         <= {NUM_REQ{1'b0}};
      end
      r_tag_valid[0] <= w_access & ~bus.we_i[r_owner_id];
      r_tag_id[0]    <= r_owner_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_id[i]    <= r_tag_id[i-1];
      end
    end
  end

  // Final tag stage lines up with the controller's read data.
  always_comb begin
    w_rd_valid                             = {NUM_REQ{1'b0}};
    w_rd_valid[r_tag_id[READ_LATENCY-1]]   = r_tag_valid[READ_LATENCY-1];
  end

  assign bus.gnt_o           = r_gnt;
  assign bus.rd_valid_o      = w_rd_valid;
  assign bus.rd_data_o       = bus.SRAM_read_data_i;
  assign bus.reads_pending_o = |r_tag_valid;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM emulator, queue-based reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = SRAM_ADDR_W;
  localparam int DW = SRAM_DATA_W;
  localparam int RL = SRAM_READ_LATENCY;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sram_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [N-1:0]    t_req   = '0;
  logic [N-1:0]    t_lock  = '0;
  logic [N-1:0]    t_we    = '0;
  logic [N*AW-1:0] t_addr  = '0;
  logic [N*DW-1:0] t_wdata = '0;

  assign bus.req_i   = t_req;
  assign bus.lock_i  = t_lock;
  assign bus.we_i    = t_we;
  assign bus.addr_i  = t_addr;
  assign bus.wdata_i = t_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pre(input int a);
    logic [31:0] v;
    v = a;
    return 16'hA000 ^ v[15:0];
  endfunction

  // SRAM controller emulator: read data appears RL cycles after the access.
  logic [DW-1:0] emu_mem [0:(1<<AW)-1];
  logic [DW-1:0] emu_p0 = '0, emu_p1 = '0, emu_p2 = '0;
  logic          cap_we = 1'b0;
  logic [AW-1:0] cap_a  = '0;
  logic [DW-1:0] cap_d  = '0, cap_rd = '0;
  assign bus.SRAM_read_data_i = emu_p2;

  initial forever begin
    @(negedge clk);
    cap_we = ~bus.SRAM_we_n_o;
    cap_a  = bus.SRAM_address_o;
    cap_d  = bus.SRAM_write_data_o;
    cap_rd = emu_mem[cap_a];
  end

  initial forever begin
    @(posedge clk);
    if (cap_we) emu_mem[cap_a] = cap_d;
    emu_p2 = emu_p1;
    emu_p1 = emu_p0;
    emu_p0 = cap_rd;
  end

  // Reference model: owner, rotation pointer, outstanding reads as a queue.
  typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;
  typedef struct { int cyc; int id; logic [DW-1:0] data; } ev_t;
  rd_t           mq [$];
  ev_t           rv_log [$];
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  int            m_owner = -1;
  int            m_last  = N - 1;

  task automatic m_reset();
    mq.delete();
    m_owner = -1;
    m_last  = N - 1;
  endtask

  task automatic model_step();
    int  o;
    bit  acc;
    logic [AW-1:0] a;
    rd_t e;
    o   = m_owner;
    acc = (o >= 0) && t_req[o];
    while (mq.size() > 0 && mq[0].due <= cyc) void'(mq.pop_front());
    if (acc) begin
      a = t_addr[o*AW +: AW];
      if (t_we[o]) m_mem[a] = t_wdata[o*DW +: DW];
      else begin
        e.due = cyc + RL; e.id = o; e.data = m_mem[a];
        mq.push_back(e);
      end
    end
    if (!(acc && t_lock[o])) begin
      m_owner = -1;
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && t_req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_last  = m_owner;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) m_reset();
    else model_step();
    cyc++;
  end

  initial forever begin
    @(posedge rst);
    m_reset();
  end

  task automatic check_cycle();
    logic [N-1:0] eg, erv;
    int   sel;
    bit   acc;
    ev_t  ev;
    sel = (m_owner >= 0) ? m_owner : 0;
    acc = (m_owner >= 0) && t_req[sel];
    eg  = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    erv = '0;
    if (mq.size() > 0 && mq[0].due == cyc) erv[mq[0].id] = 1'b1;
    chk("gnt",      bus.gnt_o, eg);
    chk("we_n",     bus.SRAM_we_n_o, !(acc && t_we[sel]));
    chk("addr",     bus.SRAM_address_o, t_addr[sel*AW +: AW]);
    chk("wdata",    bus.SRAM_write_data_o, t_wdata[sel*DW +: DW]);
    chk("rd_valid", bus.rd_valid_o, erv);
    chk("pending",  bus.reads_pending_o, mq.size() > 0);
    if (erv != '0) chk("rd_data", bus.rd_data_o, mq[0].data);
    for (int i = 0; i < N; i++) begin
      if (bus.rd_valid_o[i]) begin
        ev.cyc = cyc; ev.id = i; ev.data = bus.rd_data_o;
        rv_log.push_back(ev);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    check_cycle();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic set_req(input int i, input logic r, input logic l, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    t_req[i]  = r;
    t_lock[i] = l;
    t_we[i]   = w;
    t_addr[i*AW +: AW]  = a;
    t_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int mark, s, rc;
    for (int i = 0; i < (1 << AW); i++) begin
      emu_mem[i] = pre(i);
      m_mem[i]   = pre(i);
    end
    #2 rst = 1'b1;
    repeat (3) step();
    mid();
    chk("rst_gnt", bus.gnt_o, 4'b0000);
    chk("rst_we_n", bus.SRAM_we_n_o, 1'b1);
    chk("rst_pend", bus.reads_pending_o, 1'b0);
    chk("rst_rv", bus.rd_valid_o, 4'b0000);
    chk("rst_addr", bus.SRAM_address_o, 18'd0);
    step();
    rst = 1'b0;
    step();

    // Single-requester read burst from M1, addresses 0..7.
    set_req(REQ_M1, 1'b1, 1'b0, 1'b0, 18'd0, 16'h0000);
    step();
    s = cyc;
    mark = rv_log.size();
    for (int k = 0; k < 8; k++) begin
      t_addr[REQ_M1*AW +: AW] = AW'(k);
      mid();
      chk("burst_gnt", bus.gnt_o, 4'b0010);
      step();
    end
    t_req = '0;
    repeat (6) step();
    chk("burst_cnt", rv_log.size() - mark, 8);
    for (int k = 0; k < 8 && mark + k < rv_log.size(); k++) begin
      chk("burst_cyc", rv_log[mark+k].cyc, s + 3 + k);
      chk("burst_id", rv_log[mark+k].id, 1);
      chk("burst_data", rv_log[mark+k].data, 16'hA000 + k);
    end

    // Round-robin with all four requesting, starting fresh from reset.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(i), 16'h0000);
    step();
    s = cyc;
    mark = rv_log.size();
    for (int k = 0; k < 8; k++) begin
      mid();
      chk("rr_gnt", bus.gnt_o, 4'b0001 << (k % 4));
      step();
    end
    t_req = '0;
    repeat (6) step();
    chk("rr_cnt", rv_log.size() - mark, 8);
    for (int k = 0; k < 8 && mark + k < rv_log.size(); k++) begin
      chk("rr_id", rv_log[mark+k].id, k % 4);
      chk("rr_data", rv_log[mark+k].data, 16'hA000 + (k % 4));
      chk("rr_cyc", rv_log[mark+k].cyc, s + 3 + k);
    end

    // M2 locked write burst of 64 while UART waits.
    set_req(REQ_M2, 1'b1, 1'b1, 1'b1, 18'd100, 16'h1000);
    step();
    set_req(REQ_UART, 1'b1, 1'b0, 1'b0, 18'd0, 16'h0000);
    for (int k = 0; k < 64; k++) begin
      t_addr[REQ_M2*AW +: AW]  = AW'(100 + k);
      t_wdata[REQ_M2*DW +: DW] = DW'(16'h1000 + k);
      mid();
      chk("lock_gnt", bus.gnt_o, 4'b0100);
      chk("lock_we_n", bus.SRAM_we_n_o, 1'b0);
      step();
    end
    t_req[REQ_M2]  = 1'b0;
    t_lock[REQ_M2] = 1'b0;
    mid();
    chk("lock_drop_gnt", bus.gnt_o, 4'b0100);
    step();
    mid();
    chk("uart_after_lock", bus.gnt_o, 4'b0001);
    step();
    t_req = '0;
    repeat (6) step();

    // Write then read the same address from M1.
    mark = rv_log.size();
    set_req(REQ_M1, 1'b1, 1'b0, 1'b1, 18'd146944, 16'hBEEF);
    step();
    step();
    t_we[REQ_M1] = 1'b0;
    rc = cyc;
    step();
    t_req = '0;
    repeat (6) step();
    chk("rw_cnt", rv_log.size() - mark, 1);
    if (rv_log.size() > mark) begin
      chk("rw_data", rv_log[mark].data, 16'hBEEF);
      chk("rw_id", rv_log[mark].id, 1);
      chk("rw_cyc", rv_log[mark].cyc, rc + 3);
    end

    // Reset while three M3 reads are in flight.
    mark = rv_log.size();
    set_req(REQ_M3, 1'b1, 1'b0, 1'b0, 18'd50, 16'h0000);
    step(); step(); step(); step();
    t_req = '0;
    rst = 1'b1;
    mid();
    chk("mid_rst_gnt", bus.gnt_o, 4'b0000);
    chk("mid_rst_pend", bus.reads_pending_o, 1'b0);
    chk("mid_rst_we_n", bus.SRAM_we_n_o, 1'b1);
    chk("mid_rst_rv", bus.rd_valid_o, 4'b0000);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("mid_rst_no_pulse", rv_log.size() - mark, 0);
    chk("post_rst_pend", bus.reads_pending_o, 1'b0);

    // Idle gap, then a lone request from M3.
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("idle_gnt", bus.gnt_o, 4'b0000);
      chk("idle_we_n", bus.SRAM_we_n_o, 1'b1);
      step();
    end
    set_req(REQ_M3, 1'b1, 1'b0, 1'b0, 18'd7, 16'h0000);
    mid();
    chk("idle_req_cycle_gnt", bus.gnt_o, 4'b0000);
    step();
    mid();
    chk("idle_next_gnt", bus.gnt_o, 4'b1000);
    step();
    t_req = '0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
